hera_prog_loader: RTL
=====================

# hera_prog_loader

Boot-time program loader sitting directly upstream of the HERA core. It accepts a byte stream (host/UART side) carrying a framed program image and writes 16-bit instruction words into the core's instruction memory. It holds the core in reset until a complete, checksum-verified image has been written. It then releases the core's reset and stays idle until the next system reset.

## Interface
Parameters:
- ADDR_W, 8: instruction memory address width; capacity 2^ADDR_W words.
- BOOT_HOLD, 4: cycles the core stays in reset after a good checksum; legal range ≥1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  byte on in_data is valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte. A byte transfers on a rising edge when in_valid and in_ready are both 1.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  16  write data, {high byte, low byte}.
- core_rst  out  1  active-low reset to the HERA core.
- load_done  out  1  image loaded and core released.
- load_err  out  1  framing or checksum error; sticky until the next sync byte is accepted.

## Operation
- Frame format: sync 0xA5, then LEN_HI and LEN_LO giving word count N (big-endian), then N words as two bytes each, high byte first, then CSUM.
- CSUM must equal the mod-256 sum of every byte from LEN_HI through the last data byte.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM, HOLD, RUN.
- IDLE: accepted bytes other than 0xA5 are discarded. An accepted 0xA5 clears load_err, clears the running sum, and moves to LEN_HI.
- LEN_HI → LEN_LO → length check:
  - N = 0 or N > 2^ADDR_W: set load_err and return to IDLE.
  - Otherwise: word index = 0, go to DATA_HI.
- DATA_HI latches the high byte. Accepting a byte in DATA_LO registers a write with imem_addr = index and imem_wdata = {hi, lo}, then increments the index.
  - If the index reaches N, go to CSUM; otherwise go to DATA_HI.
- CSUM:
  - Match: go to HOLD.
  - Mismatch: set load_err and return to IDLE. core_rst stays 0. Memory contents already written are left as is and are don't-care.
- HOLD: counts BOOT_HOLD cycles, then goes to RUN.
- RUN: core_rst = 1 and load_done = 1. The stream is ignored. RUN is left only by rst.
- in_ready = 1 in IDLE through CSUM; 0 in HOLD and RUN.
- Running sum is 8 bits and wraps. Word index is ADDR_W+1 bits wide so that N = 2^ADDR_W is representable. imem_addr is the low ADDR_W bits of the index.

## Timing
- Reset values while rst = 0 (take effect immediately, asynchronously):
  - in_ready = 0, imem_we = 0, imem_addr = 0, imem_wdata = 0.
  - core_rst = 0, load_done = 0, load_err = 0.
  - State = IDLE.
- in_ready rises on the first rising edge after rst deasserts.
- Data writes: if the DATA_LO byte is accepted at edge t, imem_we is 1 from edge t to edge t+1, with imem_addr and imem_wdata stable over the same interval. imem_we is never high two cycles for one word. Back-to-back words give at most one write every 2 cycles.
- Boot: if the CSUM byte is accepted at edge c and matches, core_rst and load_done both rise at edge c+BOOT_HOLD+1, in the same cycle. in_ready falls at edge c.
- Errors: load_err rises at the edge that accepts the offending LEN_LO or CSUM byte. It falls at the edge that accepts the next 0xA5 in IDLE.
- Stalls: in_valid gaps may occur in any state. The FSM holds its state, no writes occur, and the running sum is unchanged.
- A 0xA5 byte arriving inside a frame is treated as data, not as a resync.
- Reset mid-frame: all outputs return to reset values immediately. No partial write is emitted after rst deasserts. The next frame loads from address 0.

## Test plan
- Good load, ADDR_W=8, BOOT_HOLD=4. Stream A5 00 02 E0 01 F1 02 D6 →
  - writes addr0 = 0xE001, then addr1 = 0xF102;
  - core_rst and load_done rise 5 cycles after D6 is accepted;
  - load_err stays 0.
- Garbage first: stream 00 FF 3C, then the good frame above → identical writes and boot timing; no load_err.
- Bad checksum: CSUM = D7 → load_err = 1, core_rst stays 0, in_ready = 1. A following good frame clears load_err at its A5 and boots normally.
- Length errors:
  - A5 00 00 → load_err at LEN_LO acceptance; no writes.
  - A5 01 01 (N = 257 > 256) → same.
- Back-pressure: good frame with in_valid toggling 1/0 every cycle → same two writes with correct addr and data; boot occurs 5 cycles after CSUM acceptance.
- Async reset mid-frame: drop rst for a partial cycle after the first data word is written → outputs reset immediately with no clock edge needed. A fresh good frame then rewrites from addr0 and boots.

Source files
------------

// File: rtl/hera_prog_loader_if.sv
// Byte-stream input and instruction-memory/core-control outputs of the program loader.
interface hera_prog_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              core_rst;
  logic              load_done;
  logic              load_err;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, core_rst, load_done, load_err
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, core_rst, load_done, load_err
  );
endinterface

// File: rtl/hera_prog_loader.sv
// Boot loader: parses A5/len/words/csum frames into imem writes, then releases the core.
// Latency: write registered one edge after DATA_LO accept; core release BOOT_HOLD+1 edges after good CSUM.
// Backpressure: in_ready high from IDLE through CSUM, low once booting; in_valid gaps simply stall the FSM.
module hera_prog_loader #(
  parameter int ADDR_W    = 8,
  parameter int BOOT_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  hera_prog_loader_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM, S_HOLD, S_RUN
  } state_t;

  localparam int          IW        = ADDR_W + 1;
  localparam int          HW        = $clog2(BOOT_HOLD + 1);
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  state_t            state, state_nxt;
  logic [7:0]        sum, len_hi, hi_byte;
  logic [IW-1:0]     idx, len;
  logic [HW-1:0]     hold_cnt;
  logic              ready_q, we_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;

  logic              accept, set_err, clr_err, wr;
  logic [16:0]       len_word;
  logic              len_bad;
  logic [IW-1:0]     idx_inc;
  logic              hold_done;

  assign accept    = bus.in_valid && ready_q;
  assign len_word  = {1'b0, len_hi, bus.in_data};
  assign len_bad   = (len_word == 17'd0) || (len_word > MAX_WORDS);
  assign idx_inc   = idx + IW'(1);
  assign hold_done = (hold_cnt == HW'(BOOT_HOLD));

  always_comb begin
    state_nxt = state;
    set_err   = 1'b0;
    clr_err   = 1'b0;
    wr        = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept && bus.in_data == 8'hA5) begin
          state_nxt = S_LEN_HI;
          clr_err   = 1'b1;
        end
      end
      S_LEN_HI: if (accept) state_nxt = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if (len_bad) begin
            state_nxt = S_IDLE;
            set_err   = 1'b1;
          end else begin
            state_nxt = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: if (accept) state_nxt = S_DATA_LO;
      S_DATA_LO: begin
        if (accept) begin
          wr        = 1'b1;
          state_nxt = (idx_inc == len) ? S_CSUM : S_DATA_HI;
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (bus.in_data == sum) begin
            state_nxt = S_HOLD;
          end else begin
            state_nxt = S_IDLE;
            set_err   = 1'b1;
          end
        end
      end
      S_HOLD:  if (hold_done) state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      sum      <= '0;
      len_hi   <= '0;
      hi_byte  <= '0;
      idx      <= '0;
      len      <= '0;
      hold_cnt <= '0;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt != S_HOLD) && (state_nxt != S_RUN);
      we_q    <= wr;

      if (clr_err)      err_q <= 1'b0;
      else if (set_err) err_q <= 1'b1;

      // Checksum covers LEN_HI through the last data byte; the sync byte restarts it.
      if (state == S_IDLE && clr_err)
        sum <= '0;
      else if (accept && (state == S_LEN_HI || state == S_LEN_LO ||
                          state == S_DATA_HI || state == S_DATA_LO))
        sum <= sum + bus.in_data;

      if (accept && state == S_LEN_HI) len_hi <= bus.in_data;
      if (accept && state == S_LEN_LO && !len_bad) begin
        len <= len_word[IW-1:0];
        idx <= '0;
      end
      if (accept && state == S_DATA_HI) hi_byte <= bus.in_data;
      if (wr) begin
        addr_q  <= idx[ADDR_W-1:0];
        wdata_q <= {hi_byte, bus.in_data};
        idx     <= idx_inc;
      end

      if (state != S_HOLD)  hold_cnt <= '0;
      else if (!hold_done)  hold_cnt <= hold_cnt + HW'(1);
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.core_rst   = (state == S_RUN);
  assign bus.load_done  = (state == S_RUN);
  assign bus.load_err   = err_q;
endmodule
